// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the synchronous FIFO controller.
//   ptr_wrap_inc - pointer increment that wraps at an arbitrary depth
//   limit_ok     - legality test for the reach_limit threshold
//   ae_ok        - legality test for the almost_empty threshold
package fifo_pkg;

  // Wrap with an explicit compare so that depths which are not a power of
  // two still index only the valid entries 0..depth-1.
  function automatic logic [31:0] ptr_wrap_inc(input logic [31:0] ptr,
                                               input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

  function automatic bit limit_ok(input int limit, input int depth);
    return (limit >= 1) && (limit <= depth);
  endfunction

  function automatic bit ae_ok(input int ae, input int depth);
    return (ae >= 0) && (ae < depth);
  endfunction

endpackage

// File: rtl/sync_ram_dp.sv
// sync_ram_dp: WIDTH x DEPTH storage array.
//   clk   - clock
//   we    - write strobe; wdata is stored at waddr on the rising edge
//   waddr - write index
//   wdata - write data
//   raddr - read index
//   rdata - combinational read of mem[raddr]
// Contents are never reset.
module sync_ram_dp #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with occupancy counter, standard or
// first-word-fall-through read, programmable thresholds, sticky errors.
//   clk, rst      - clock; synchronous active-high reset
//   enable        - 0 freezes all state (clear still honoured)
//   clear         - synchronous flush, data_bus_out holds
//   data_bus_in   - write data, write_ins - write request
//   read_ins      - read request (standard) / pop (FWFT)
//   data_bus_out  - read data, data_valid - read strobe / !empty in FWFT
//   full, empty, reach_limit, almost_empty, count - occupancy status
//   overflow, underflow - sticky rejected-request flags
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH              = 512,
  parameter int WIDTH              = 8,
  parameter int FWFT               = 0,
  parameter int LIMIT_COUNTER      = 58,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter int COUNTER_WIDTH      = $clog2(DEPTH + 1),
  parameter int PTR_WIDTH          = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         data_bus_in,
  input  logic                     write_ins,
  input  logic                     read_ins,
  output logic [WIDTH-1:0]         data_bus_out,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     reach_limit,
  output logic                     almost_empty,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic                     overflow,
  output logic                     underflow
);

  if (!limit_ok(LIMIT_COUNTER, DEPTH)) begin : g_bad_limit
    $error("sync_fifo_ctrl: LIMIT_COUNTER must be within 1..DEPTH");
  end
  if (!ae_ok(ALMOST_EMPTY_LEVEL, DEPTH)) begin : g_bad_ae
    $error("sync_fifo_ctrl: ALMOST_EMPTY_LEVEL must be within 0..DEPTH-1");
  end

  logic [PTR_WIDTH-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_WIDTH-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [COUNTER_WIDTH-1:0] count_reg, count_next;
  logic                     overflow_reg, overflow_next;
  logic                     underflow_reg, underflow_next;
  logic [WIDTH-1:0]         dout_reg, dout_next;
  logic                     dv_reg, dv_next;
  logic [WIDTH-1:0]         ram_rdata;
  logic                     active, rd_acc, wr_acc;

  // Status is a pure function of the occupancy counter.
  assign full         = (count_reg == COUNTER_WIDTH'(DEPTH));
  assign empty        = (count_reg == '0);
  assign reach_limit  = (count_reg >= COUNTER_WIDTH'(LIMIT_COUNTER));
  assign almost_empty = (count_reg <= COUNTER_WIDTH'(ALMOST_EMPTY_LEVEL));
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // Requests are only considered in an ordinary enabled cycle; reset and
  // flush swallow any same-cycle request without touching the flags.
  assign active = enable && !clear && !rst;
  assign rd_acc = active && read_ins && !empty;
  // A full FIFO still takes a write when a read frees the slot this edge.
  assign wr_acc = active && write_ins && (!full || rd_acc);

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    dout_next      = dout_reg;
    dv_next        = 1'b0;
    if (clear) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else if (active) begin
      if (wr_acc) begin
        wr_ptr_next = PTR_WIDTH'(ptr_wrap_inc(32'(wr_ptr_reg), 32'(DEPTH)));
      end
      if (rd_acc) begin
        rd_ptr_next = PTR_WIDTH'(ptr_wrap_inc(32'(rd_ptr_reg), 32'(DEPTH)));
        dout_next   = ram_rdata;
        dv_next     = 1'b1;
      end
      if (write_ins && !wr_acc) begin
        overflow_next = 1'b1;
      end
      if (read_ins && !rd_acc) begin
        underflow_next = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      dout_reg      <= '0;
      dv_reg        <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      dout_reg      <= dout_next;
      dv_reg        <= dv_next;
    end
  end

  sync_ram_dp #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (PTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_reg),
    .wdata (data_bus_in),
    .raddr (rd_ptr_reg),
    .rdata (ram_rdata)
  );

  // FWFT exposes the head entry directly; standard mode uses the output
  // register loaded on each accepted read.
  if (FWFT != 0) begin : g_fwft
    assign data_bus_out = ram_rdata;
    assign data_valid   = !empty;
  end else begin : g_std
    assign data_bus_out = dout_reg;
    assign data_valid   = dv_reg;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, clear;
  // standard-mode instance
  logic [7:0] s_din, s_dout;
  logic       s_wr, s_rd, s_dv, s_full, s_empty, s_rl, s_ae, s_ovf, s_unf;
  logic [3:0] s_count;
  // FWFT instance
  logic [7:0] f_din, f_dout;
  logic       f_wr, f_rd, f_dv, f_full, f_empty, f_rl, f_ae, f_ovf, f_unf;
  logic [3:0] f_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DEPTH(8), .WIDTH(8), .FWFT(0), .LIMIT_COUNTER(6), .ALMOST_EMPTY_LEVEL(2)
  ) dut_std (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .data_bus_in(s_din), .write_ins(s_wr), .read_ins(s_rd),
    .data_bus_out(s_dout), .data_valid(s_dv), .full(s_full), .empty(s_empty),
    .reach_limit(s_rl), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_ctrl #(
    .DEPTH(8), .WIDTH(8), .FWFT(1), .LIMIT_COUNTER(6), .ALMOST_EMPTY_LEVEL(2)
  ) dut_fwft (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .data_bus_in(f_din), .write_ins(f_wr), .read_ins(f_rd),
    .data_bus_out(f_dout), .data_valid(f_dv), .full(f_full), .empty(f_empty),
    .reach_limit(f_rl), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; clear = 1'b0;
    s_din = 8'h00; s_wr = 1'b0; s_rd = 1'b0;
    f_din = 8'h00; f_wr = 1'b0; f_rd = 1'b0;
    step(); step();
    rst = 1'b0;
    if (s_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", s_count);
    else pass_cnt++;
    total_cnt++;
    // {full, empty, reach_limit, almost_empty, overflow, underflow, data_valid}
    if ({s_full, s_empty, s_rl, s_ae, s_ovf, s_unf, s_dv} !== 7'b0101000)
      $display("FAIL reset_flags: got %b expected 0101000",
               {s_full, s_empty, s_rl, s_ae, s_ovf, s_unf, s_dv});
    else pass_cnt++;
    total_cnt++;
    if (s_dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", s_dout);
    else pass_cnt++;
    total_cnt++;
    if ({f_count, f_empty, f_dv} !== {4'd0, 1'b1, 1'b0})
      $display("FAIL reset_fwft: got count=%0d empty=%b dv=%b expected 0 1 0",
               f_count, f_empty, f_dv);
    else pass_cnt++;
    total_cnt++;
    $display("reset done");
  endtask

  task automatic test_fwft();
    f_din = 8'h3C; f_wr = 1'b1;
    step();
    f_wr = 1'b0;
    $display("fwft write 3c count %0d", f_count);
    if ({f_dout, f_dv, f_count} !== {8'h3C, 1'b1, 4'd1})
      $display("FAIL fwft_visible: got dout=%h dv=%b count=%0d expected 3c 1 1",
               f_dout, f_dv, f_count);
    else pass_cnt++;
    total_cnt++;
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    $display("fwft pop count %0d", f_count);
    if ({f_empty, f_dv} !== 2'b10)
      $display("FAIL fwft_pop_empty: got empty=%b dv=%b expected 1 0", f_empty, f_dv);
    else pass_cnt++;
    total_cnt++;
    f_wr = 1'b1;
    f_din = 8'hA1; step();
    f_din = 8'hA2; step();
    f_wr = 1'b0;
    if ({f_dout, f_count} !== {8'hA1, 4'd2})
      $display("FAIL fwft_head: got dout=%h count=%0d expected a1 2", f_dout, f_count);
    else pass_cnt++;
    total_cnt++;
    f_rd = 1'b1;
    step();
    if ({f_dout, f_dv} !== {8'hA2, 1'b1})
      $display("FAIL fwft_next: got dout=%h dv=%b expected a2 1", f_dout, f_dv);
    else pass_cnt++;
    total_cnt++;
    step();  // pops A2
    step();  // pop on empty
    f_rd = 1'b0;
    if ({f_empty, f_unf} !== 2'b11)
      $display("FAIL fwft_underflow: got empty=%b unf=%b expected 1 1", f_empty, f_unf);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      s_din = 8'(i); s_wr = 1'b1;
      step();
      $display("write %h count %0d", s_din, s_count);
      if (s_count !== 4'(i))
        $display("FAIL fill_count: got %0d expected %0d", s_count, i);
      else pass_cnt++;
      total_cnt++;
      if ({s_full, s_empty, s_rl, s_ae} !== {(i == 8), 1'b0, (i >= 6), (i <= 2)})
        $display("FAIL fill_flags: got %b expected %b at count %0d",
                 {s_full, s_empty, s_rl, s_ae}, {(i == 8), 1'b0, (i >= 6), (i <= 2)}, i);
      else pass_cnt++;
      total_cnt++;
    end
    s_din = 8'hAA;
    step();
    s_wr = 1'b0;
    $display("write aa (full) count %0d", s_count);
    if ({s_ovf, s_count} !== {1'b1, 4'd8})
      $display("FAIL fill_overflow: got ovf=%b count=%0d expected 1 8", s_ovf, s_count);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      s_rd = 1'b1;
      step();
      s_rd = 1'b0;
      $display("read %h count %0d", s_dout, s_count);
      if ({s_dout, s_dv, s_count} !== {8'(i), 1'b1, 4'(8 - i)})
        $display("FAIL drain_data: got dout=%h dv=%b count=%0d expected %h 1 %0d",
                 s_dout, s_dv, s_count, 8'(i), 8 - i);
      else pass_cnt++;
      total_cnt++;
      step();
      if ({s_dout, s_dv} !== {8'(i), 1'b0})
        $display("FAIL drain_idle: got dout=%h dv=%b expected %h 0", s_dout, s_dv, 8'(i));
      else pass_cnt++;
      total_cnt++;
    end
    s_rd = 1'b1;
    step();
    s_rd = 1'b0;
    $display("read on empty unf %b", s_unf);
    if ({s_empty, s_unf, s_dv, s_dout} !== {1'b1, 1'b1, 1'b0, 8'h08})
      $display("FAIL drain_underflow: got empty=%b unf=%b dv=%b dout=%h expected 1 1 0 08",
               s_empty, s_unf, s_dv, s_dout);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_q [8];
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};
    clear = 1'b1;
    step();
    clear = 1'b0;
    if ({s_count, s_ovf, s_unf, s_dout} !== {4'd0, 1'b0, 1'b0, 8'h08})
      $display("FAIL clear_state: got count=%0d ovf=%b unf=%b dout=%h expected 0 0 0 08",
               s_count, s_ovf, s_unf, s_dout);
    else pass_cnt++;
    total_cnt++;
    s_wr = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_din = 8'(i);
      step();
    end
    s_din = 8'h55; s_rd = 1'b1;
    step();
    s_wr = 1'b0;
    $display("write 55 + read %h while full count %0d", s_dout, s_count);
    if ({s_dout, s_dv, s_count, s_ovf} !== {8'h01, 1'b1, 4'd8, 1'b0})
      $display("FAIL full_rw: got dout=%h dv=%b count=%0d ovf=%b expected 01 1 8 0",
               s_dout, s_dv, s_count, s_ovf);
    else pass_cnt++;
    total_cnt++;
    for (int i = 0; i < 8; i++) begin
      step();
      $display("read %h count %0d", s_dout, s_count);
      if ({s_dout, s_dv} !== {exp_q[i], 1'b1})
        $display("FAIL wrap_drain: got dout=%h dv=%b expected %h 1", s_dout, s_dv, exp_q[i]);
      else pass_cnt++;
      total_cnt++;
    end
    s_rd = 1'b0;
    if (s_empty !== 1'b1) $display("FAIL wrap_empty: got %b expected 1", s_empty);
    else pass_cnt++;
    total_cnt++;
    s_din = 8'h99; s_wr = 1'b1; s_rd = 1'b1;
    step();
    s_wr = 1'b0; s_rd = 1'b0;
    $display("write 99 + read on empty count %0d", s_count);
    if ({s_count, s_unf, s_dv} !== {4'd1, 1'b1, 1'b0})
      $display("FAIL empty_rw: got count=%0d unf=%b dv=%b expected 1 1 0",
               s_count, s_unf, s_dv);
    else pass_cnt++;
    total_cnt++;
    s_rd = 1'b1;
    step();
    s_rd = 1'b0;
    if (s_dout !== 8'h99) $display("FAIL empty_rw_data: got %h expected 99", s_dout);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_clear_disabled();
    s_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_din = 8'h11 + 8'(i);
      step();
    end
    s_wr = 1'b0;
    if ({s_count, s_unf} !== {4'd5, 1'b1})
      $display("FAIL preclear: got count=%0d unf=%b expected 5 1", s_count, s_unf);
    else pass_cnt++;
    total_cnt++;
    enable = 1'b0; clear = 1'b1;
    step();
    enable = 1'b1; clear = 1'b0;
    $display("clear with enable=0 count %0d", s_count);
    if ({s_count, s_empty, s_ovf, s_unf} !== {4'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL clear_disabled: got count=%0d empty=%b ovf=%b unf=%b expected 0 1 0 0",
               s_count, s_empty, s_ovf, s_unf);
    else pass_cnt++;
    total_cnt++;
    s_din = 8'h77; s_wr = 1'b1;
    step();
    s_wr = 1'b0; s_rd = 1'b1;
    step();
    s_rd = 1'b0;
    $display("read %h after clear", s_dout);
    if ({s_dout, s_dv} !== {8'h77, 1'b1})
      $display("FAIL clear_ptrs: got dout=%h dv=%b expected 77 1", s_dout, s_dv);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_enable_freeze();
    s_wr = 1'b1;
    s_din = 8'h10; step();
    s_din = 8'h20; step();
    s_din = 8'h30; step();
    enable = 1'b0; s_rd = 1'b1; s_din = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      step();
      $display("frozen cycle %0d count %0d", i, s_count);
      if ({s_count, s_ovf, s_unf, s_dv} !== {4'd3, 3'b000})
        $display("FAIL freeze: got count=%0d ovf=%b unf=%b dv=%b expected 3 0 0 0",
                 s_count, s_ovf, s_unf, s_dv);
      else pass_cnt++;
      total_cnt++;
    end
    enable = 1'b1; s_wr = 1'b0;
    step();
    s_rd = 1'b0;
    if ({s_dout, s_count} !== {8'h10, 4'd2})
      $display("FAIL freeze_resume: got dout=%h count=%0d expected 10 2", s_dout, s_count);
    else pass_cnt++;
    total_cnt++;
    s_wr = 1'b1; s_din = 8'hF0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; s_wr = 1'b0;
    $display("reset mid-burst count %0d", s_count);
    if ({s_count, s_empty, s_ovf, s_unf, s_dv, s_dout} !== {4'd0, 1'b1, 3'b000, 8'h00})
      $display("FAIL mid_reset: got count=%0d empty=%b ovf=%b unf=%b dv=%b dout=%h expected 0 1 0 0 0 00",
               s_count, s_empty, s_ovf, s_unf, s_dv, s_dout);
    else pass_cnt++;
    total_cnt++;
    s_din = 8'hE1; s_wr = 1'b1;
    step();
    s_wr = 1'b0; s_rd = 1'b1;
    step();
    s_rd = 1'b0;
    if (s_dout !== 8'hE1) $display("FAIL post_reset_data: got %h expected e1", s_dout);
    else pass_cnt++;
    total_cnt++;
  endtask

  initial begin
    test_reset();
    test_fwft();
    test_fill();
    test_drain();
    test_full_rw();
    test_clear_disabled();
    test_enable_freeze();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
